// File: rtl/l1_dcache_pkg.sv
// Shared types for the L1 data cache: FSM states, line type and the byte-merge helper.
// A line is 8 x 32-bit words; byte lane b of a word sits at bit 8*b within that word.
package cache_types;
  localparam int S_OFFSET       = 5;
  localparam int WORDS_PER_LINE = 8;

  typedef enum logic [1:0] {IDLE, RESP, WRITEBACK, ALLOCATE} dcache_state_t;
  typedef logic [255:0] cacheline_t;

  function automatic cacheline_t merge_word(input cacheline_t line, input logic [2:0] word,
                                            input logic [3:0] be, input logic [31:0] wdata);
    cacheline_t r;
    r = line;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[32*int'(word) + 8*b +: 8] = wdata[8*b +: 8];
    end
    return r;
  endfunction
endpackage

// File: rtl/l1_dcache_array.sv
// Flop-based per-set storage with one write port and an asynchronous read on the same index.
// RESETTABLE selects an async active-low clear (used for the valid and dirty bits only).
module dcache_array #(
  parameter int WIDTH      = 1,
  parameter int S_INDEX    = 3,
  parameter bit RESETTABLE = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic [S_INDEX-1:0] i_index,
  input  logic [WIDTH-1:0]   i_din,
  output logic [WIDTH-1:0]   o_dout
);
  localparam int DEPTH = 2**S_INDEX;

  logic [WIDTH-1:0] r_mem [DEPTH];

  generate
    if (RESETTABLE) begin : g_rst
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_load) begin
          r_mem[i_index] <= i_din;
        end
      end
    end else begin : g_norst
      logic w_unused_rst;
      assign w_unused_rst = rst;
      always_ff @(posedge clk) begin
        if (i_load) r_mem[i_index] <= i_din;
      end
    end
  endgenerate

  assign o_dout = r_mem[i_index];
endmodule

// File: rtl/l1_dcache.sv
// Direct-mapped write-back, write-allocate L1 data cache between the cpu dmem port and memory.
// Hits respond the cycle after the request; misses write back a dirty victim, then fill.
module l1_dcache
  import cache_types::*;
#(
  parameter int S_INDEX = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [3:0]   mem_byte_enable,
  input  logic [31:0]  mem_address,
  input  logic [31:0]  mem_wdata,
  output logic         mem_resp,
  output logic [31:0]  mem_rdata,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic         pmem_resp,
  input  logic [255:0] pmem_rdata
);
  localparam int TAG_W = 32 - S_INDEX - S_OFFSET;

  dcache_state_t      r_state, w_state_nxt;
  logic [31:0]        r_mem_rdata;
  logic [TAG_W-1:0]   w_tag, w_tag_q;
  logic [S_INDEX-1:0] w_index;
  logic [2:0]         w_word;
  logic [1:0]         w_unused_addr;
  cacheline_t         w_line_q, w_data_din;
  logic               w_valid_q, w_dirty_q, w_hit, w_req;
  logic               w_data_load, w_tag_load, w_valid_load, w_dirty_load, w_dirty_din;

  assign w_tag         = mem_address[31:S_INDEX+S_OFFSET];
  assign w_index       = mem_address[S_INDEX+S_OFFSET-1:S_OFFSET];
  assign w_word        = mem_address[4:2];
  assign w_unused_addr = mem_address[1:0];
  assign w_req         = mem_read | mem_write;
  assign w_hit         = w_valid_q && (w_tag_q == w_tag);

  dcache_array #(.WIDTH(256), .S_INDEX(S_INDEX), .RESETTABLE(1'b0)) u_data (
    .clk(clk), .rst(rst), .i_load(w_data_load), .i_index(w_index), .i_din(w_data_din), .o_dout(w_line_q));
  dcache_array #(.WIDTH(TAG_W), .S_INDEX(S_INDEX), .RESETTABLE(1'b0)) u_tag (
    .clk(clk), .rst(rst), .i_load(w_tag_load), .i_index(w_index), .i_din(w_tag), .o_dout(w_tag_q));
  dcache_array #(.WIDTH(1), .S_INDEX(S_INDEX), .RESETTABLE(1'b1)) u_valid (
    .clk(clk), .rst(rst), .i_load(w_valid_load), .i_index(w_index), .i_din(1'b1), .o_dout(w_valid_q));
  dcache_array #(.WIDTH(1), .S_INDEX(S_INDEX), .RESETTABLE(1'b1)) u_dirty (
    .clk(clk), .rst(rst), .i_load(w_dirty_load), .i_index(w_index), .i_din(w_dirty_din), .o_dout(w_dirty_q));

  always_comb begin
    w_state_nxt  = r_state;
    w_data_load  = 1'b0;
    w_data_din   = merge_word(w_line_q, w_word, mem_byte_enable, mem_wdata);
    w_tag_load   = 1'b0;
    w_valid_load = 1'b0;
    w_dirty_load = 1'b0;
    w_dirty_din  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_req) begin
          if (w_hit) begin
            w_state_nxt = RESP;
            // A simultaneous read+write is handled as a write.
            if (mem_write) begin
              w_data_load  = 1'b1;
              w_dirty_load = |mem_byte_enable;
              w_dirty_din  = 1'b1;
            end
          end else if (w_valid_q && w_dirty_q) begin
            w_state_nxt = WRITEBACK;
          end else begin
            w_state_nxt = ALLOCATE;
          end
        end
      end
      RESP: w_state_nxt = IDLE;
      WRITEBACK: begin
        if (pmem_resp) begin
          w_dirty_load = 1'b1;
          w_state_nxt  = ALLOCATE;
        end
      end
      ALLOCATE: begin
        if (pmem_resp) begin
          w_data_load  = 1'b1;
          w_data_din   = pmem_rdata;
          w_tag_load   = 1'b1;
          w_valid_load = 1'b1;
          w_dirty_load = 1'b1;
          w_state_nxt  = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_mem_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_req && w_hit && !mem_write)
        r_mem_rdata <= w_line_q[32*int'(w_word) +: 32];
    end
  end

  assign mem_resp   = (r_state == RESP);
  assign mem_rdata  = r_mem_rdata;
  assign pmem_write = (r_state == WRITEBACK);
  assign pmem_read  = (r_state == ALLOCATE);
  assign pmem_wdata = (r_state == WRITEBACK) ? w_line_q : '0;

  always_comb begin
    pmem_address = '0;
    if (r_state == WRITEBACK)     pmem_address = {w_tag_q, w_index, 5'b0};
    else if (r_state == ALLOCATE) pmem_address = {mem_address[31:5], 5'b0};
  end
endmodule
